mem_stage: RTL and testbench

- Consumer of the 64-bit EX/MEM pipeline buffer emitted by exec.
- Unpacks the buffer and runs a req/ack handshake with data memory for loads and stores.
- Resolves branches from the ALU flags.
- Registers a compact MEM/WB buffer for writeback, and stalls upstream while a memory access is outstanding.

---
 rtl/mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: unpacks the EX/MEM buffer, runs the data-memory req/ack handshake, resolves branches.
// Optional REQ watchdog with sticky errFlag is enabled by defining MEM_TIMEOUT_EN.
//   state | meaning
//   IDLE  | capture path open; ALU/branch/bubble results written back in one cycle
//   REQ   | memory access outstanding; upstream stalled until memAck (or timeout)
module mem_stage #(
  parameter int N       = 24,
  parameter int BW      = 64,
  parameter int OW      = 30,
  parameter int AW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [BW-1:0] bufferIn,
  input  logic [N-1:0]  memRData,
  input  logic          memAck,
  output logic          memReq,
  output logic          memWe,
  output logic [AW-1:0] memAddr,
  output logic [N-1:0]  memWData,
  output logic          stall,
  output logic          branchTaken,
  output logic [N-1:0]  branchTarget,
  output logic          errFlag,
  output logic [OW-1:0] bufferOut
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t state_q, state_d;

  logic [N-1:0] rd3, alu_result;
  logic [3:0]   rc_in, op_code;
  logic         reg_write_in, mem_to_reg, mem_write;
  logic         branch_flag, neg_flag, zero_flag;

  assign rd3          = bufferIn[23:0];
  assign rc_in        = bufferIn[27:24];
  assign reg_write_in = bufferIn[28];
  assign mem_to_reg   = bufferIn[29];
  assign mem_write    = bufferIn[30];
  assign branch_flag  = bufferIn[31];
  assign neg_flag     = bufferIn[32];
  assign zero_flag    = bufferIn[33];
  assign alu_result   = bufferIn[57:34];
  assign op_code      = bufferIn[61:58];

  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [N-1:0]  mem_wdata_q, mem_wdata_d;
  logic [3:0]    rc_q, rc_d;
  logic          reg_write_q, reg_write_d;
  logic          br_taken_q, br_taken_d;
  logic [N-1:0]  br_target_q, br_target_d;
  logic [OW-1:0] buf_out_q, buf_out_d;
  logic          take;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    case (op_code[2:0])
      3'd0:    take = 1'b1;
      3'd1:    take = zero_flag;
      3'd2:    take = !zero_flag;
      3'd3:    take = neg_flag;
      3'd4:    take = !neg_flag;
      3'd5:    take = !neg_flag && !zero_flag;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rc_d        = rc_q;
    reg_write_d = reg_write_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    buf_out_d   = buf_out_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    if (state_q == IDLE) begin
      if (en) begin
        br_taken_d  = branch_flag && take;
        br_target_d = branch_flag ? alu_result : '0;
        if (mem_write || mem_to_reg) begin
          // a store that also claims memToReg never writes back
          state_d     = REQ;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_write;
          mem_addr_d  = alu_result[AW-1:0];
          mem_wdata_d = rd3;
          rc_d        = rc_in;
          reg_write_d = reg_write_in && !mem_write;
          buf_out_d   = '0;
`ifdef MEM_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else begin
          buf_out_d = {1'b1, reg_write_in, rc_in, alu_result};
        end
      end
    end else begin
      if (memAck) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        buf_out_d = mem_we_q ? {1'b1, 1'b0, rc_q, {N{1'b0}}}
                             : {1'b1, reg_write_q, rc_q, memRData};
      end
`ifdef MEM_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        buf_out_d = '0;
        err_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rc_q        <= '0;
      reg_write_q <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      buf_out_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rc_q        <= rc_d;
      reg_write_q <= reg_write_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      buf_out_q   <= buf_out_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign memReq       = mem_req_q;
  assign memWe        = mem_we_q;
  assign memAddr      = mem_addr_q;
  assign memWData     = mem_wdata_q;
  assign stall        = (state_q == REQ);
  assign branchTaken  = br_taken_q;
  assign branchTarget = br_target_q;
  assign bufferOut    = buf_out_q;

  // opType and opCode[3] carry no meaning in this stage
`ifdef MEM_TIMEOUT_EN
  assign errFlag = err_q;
  logic unused_bits;
  assign unused_bits = ^{bufferIn[63:61]};
`else
  assign errFlag = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{bufferIn[63:61], TIMEOUT[0]};
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected MEM/WB words, a negedge monitor pops and compares.
// The watchdog scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [63:0] bufferIn = '0;
  logic [23:0] memRData = '0;
  logic        memAck = 1'b0;
  logic        memReq, memWe, stall, branchTaken, errFlag;
  logic [15:0] memAddr;
  logic [23:0] memWData, branchTarget;
  logic [29:0] bufferOut;

  mem_stage #(.N(24), .BW(64), .OW(30), .AW(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .bufferIn(bufferIn), .memRData(memRData),
    .memAck(memAck), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
    .memWData(memWData), .stall(stall), .branchTaken(branchTaken),
    .branchTarget(branchTarget), .errFlag(errFlag), .bufferOut(bufferOut)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [29:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input logic [23:0] rd3, input logic [3:0] rc,
                                     input logic rw, input logic m2r, input logic mw,
                                     input logic bf, input logic neg, input logic zero,
                                     input logic [23:0] alu, input logic [3:0] opc);
    return {2'b10, opc, alu, zero, neg, bf, mw, m2r, rw, rc, rd3};
  endfunction

  // a new MEM/WB word appears after an IDLE capture edge or on the edge that ends a stall
  logic acc_prev = 1'b0;
  logic stall_prev = 1'b0;
  always @(negedge clk) begin : monitor
    logic [29:0] e;
    if (rst && (acc_prev || (stall_prev && !stall)) && bufferOut[29]) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL wb_unexpected: got 0x%0h expected none", bufferOut);
      end else begin
        e = exp_q.pop_front();
        chk("wb_word", {2'b00, bufferOut}, {2'b00, e});
      end
    end
    acc_prev   = rst && en && !stall;
    stall_prev = rst && stall;
  end

  int t_opc[8]  = '{0, 2, 3, 4, 5, 5, 6, 7};
  int t_neg[8]  = '{0, 0, 1, 1, 0, 0, 0, 1};
  int t_zero[8] = '{0, 0, 0, 0, 0, 1, 0, 1};
  int t_take[8] = '{1, 1, 1, 0, 1, 0, 0, 0};

  initial begin
    int n;
    logic [23:0] alu;

    repeat (3) step();
    chk("rst_memReq", memReq, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_memWData", memWData, 0);
    chk("rst_bufferOut", bufferOut, 0);
    chk("rst_stall", stall, 0);
    chk("rst_branch", {branchTaken, branchTarget}, 0);
    chk("rst_errFlag", errFlag, 0);
    rst = 1'b1;
    step();

    // reset in the middle of a load; a later ack must be ignored
    bufferIn = mk(24'h0, 4'h5, 1, 1, 0, 0, 0, 0, 24'h10, 4'h0);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("midrst_req_up", memReq, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_memReq", memReq, 0);
    chk("midrst_bufferOut", bufferOut, 0);
    chk("midrst_stall", stall, 0);
    memAck = 1'b1;
    memRData = 24'h123456;
    step();
    memAck = 1'b0;
    chk("midrst_ack_ignored", bufferOut, 0);
    step();
    chk("midrst_still_zero", {memReq, bufferOut}, 0);

    // ALU op
    bufferIn = mk(24'h0, 4'h3, 1, 0, 0, 0, 0, 0, 24'h4, 4'h0);
    exp_q.push_back(30'h3300_0004);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("alu_stall", stall, 0);
    chk("alu_memReq", memReq, 0);
    step();

    // load with ack on the 4th REQ cycle
    bufferIn = mk(24'h0, 4'h5, 1, 1, 0, 0, 0, 0, 24'h10, 4'h0);
    exp_q.push_back(30'h35AB_CDEF);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("load_memAddr", memAddr, 16'h0010);
    chk("load_memWe", memWe, 0);
    chk("load_memReq", memReq, 1);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (stall) n++;
      if (i == 3) begin
        chk("load_addr_held", memAddr, 16'h0010);
        memAck = 1'b1;
        memRData = 24'hABCDEF;
      end
      step();
    end
    memAck = 1'b0;
    chk("load_stall_cycles", n, 4);
    chk("load_done_stall", stall, 0);
    chk("load_done_memReq", memReq, 0);
    step();

    // store with memToReg also set: regWrite suppressed
    bufferIn = mk(24'h7, 4'h9, 1, 1, 1, 0, 0, 0, 24'h20, 4'h0);
    exp_q.push_back(30'h2900_0000);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("store_memWe", memWe, 1);
    chk("store_memWData", memWData, 24'h7);
    chk("store_memAddr", memAddr, 16'h0020);
    chk("store_stall", stall, 1);
    memAck = 1'b1;
    step();
    memAck = 1'b0;
    chk("store_done_memReq", memReq, 0);
    step();

    // branch opCode 1 taken, then not taken
    bufferIn = mk(24'h0, 4'h0, 0, 0, 0, 1, 0, 1, 24'h40, 4'h1);
    exp_q.push_back(30'h2000_0040);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("beq_taken", branchTaken, 1);
    chk("beq_target", branchTarget, 24'h40);
    step();
    chk("beq_pulse_end", branchTaken, 0);
    bufferIn = mk(24'h0, 4'h0, 0, 0, 0, 1, 0, 0, 24'h40, 4'h1);
    exp_q.push_back(30'h2000_0040);
    en = 1'b1;
    step();
    en = 1'b0;
    chk("beq_not_taken", branchTaken, 0);
    step();

    for (int i = 0; i < 8; i++) begin
      alu = 24'h100 + 24'(i);
      bufferIn = mk(24'h0, 4'h0, 0, 0, 0, 1, t_neg[i][0], t_zero[i][0], alu, 4'(t_opc[i]));
      exp_q.push_back({6'b100000, alu});
      en = 1'b1;
      step();
      en = 1'b0;
      chk($sformatf("br_tbl%0d_taken", i), branchTaken, t_take[i]);
      chk($sformatf("br_tbl%0d_target", i), branchTarget, alu);
      step();
    end

    // ack while idle is ignored and outputs hold with en low
    memAck = 1'b1;
    memRData = 24'hFFFFFF;
    step();
    memAck = 1'b0;
    chk("idle_ack_hold", {2'b00, bufferOut}, 32'h2000_0107);
    chk("idle_ack_memReq", memReq, 0);

    // upstream holds the load during the stall, then advances to an ALU op
    bufferIn = mk(24'h0, 4'h2, 1, 1, 0, 0, 0, 0, 24'h1234, 4'h0);
    exp_q.push_back(30'h3200_0055);
    exp_q.push_back(30'h2400_0777);
    en = 1'b1;
    step();
    chk("b2b_memAddr", memAddr, 16'h1234);
    memAck = 1'b1;
    memRData = 24'h000055;
    step();
    memAck = 1'b0;
    bufferIn = mk(24'h0, 4'h4, 0, 0, 0, 0, 0, 0, 24'h777, 4'h0);
    step();
    en = 1'b0;
    chk("b2b_stall", stall, 0);
    step();

`ifdef MEM_TIMEOUT_EN
    bufferIn = mk(24'h3, 4'h1, 0, 0, 1, 0, 0, 0, 24'h30, 4'h0);
    en = 1'b1;
    step();
    en = 1'b0;
    n = 0;
    while (memReq && n < 20) begin
      step();
      n++;
    end
    chk("to_req_cycles", n, 4);
    chk("to_errFlag", errFlag, 1);
    chk("to_bufferOut", bufferOut, 0);
    chk("to_stall", stall, 0);
    repeat (3) step();
    chk("to_err_sticky", errFlag, 1);
`else
    chk("errFlag_off", errFlag, 0);
`endif

    repeat (2) step();
    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
